// File: rtl/terracresta_pkg.sv
// Shared definitions for the Terra Cresta sound command path: port map, IRQ pacing
// defaults and the 68000-to-Z80 command byte transform.
package terracresta_pkg;

    localparam int IRQ_DIV_DFLT   = 512;
    localparam int IRQ_CNT_W_DFLT = 10;

    localparam logic [7:0] SOUND_LATCH_CLR_PORT = 8'h04;
    localparam logic [7:0] SOUND_LATCH_RD_PORT  = 8'h06;

    typedef struct packed {
        logic [7:0] data;
        logic       full;
    } sound_latch_t;

    localparam sound_latch_t SOUND_LATCH_RST = '{data: 8'h00, full: 1'b0};

    // The board wires D6..D0 onto latch bits 7..1 and ties bit 0 high.
    function automatic logic [7:0] sound_cmd_xform(input logic [7:0] cmd);
        return 8'({cmd, 1'b1});
    endfunction

endpackage

// File: rtl/sound_latch_irq_if.sv
// Bus bundle between the CPU-side decoders and the sound latch / Z80 IRQ block.
interface sound_latch_irq_if;

    logic       z80_clk_en;
    logic       sound_latch_cs;
    logic       m68k_rw;
    logic       m68k_lds_n;
    logic [7:0] m68k_dout;
    logic       z80_latch_clr_cs;
    logic       z80_latch_r_cs;
    logic       z80_rd_n;
    logic       z80_wr_n;
    logic       z80_m1_n;
    logic       z80_iorq_n;
    logic [7:0] latch_dout;
    logic       latch_oe;
    logic       z80_irq_n;
    logic       latch_full;

    modport slave (
        input  z80_clk_en, sound_latch_cs, m68k_rw, m68k_lds_n, m68k_dout,
        input  z80_latch_clr_cs, z80_latch_r_cs, z80_rd_n, z80_wr_n,
        input  z80_m1_n, z80_iorq_n,
        output latch_dout, latch_oe, z80_irq_n, latch_full
    );

    modport master (
        output z80_clk_en, sound_latch_cs, m68k_rw, m68k_lds_n, m68k_dout,
        output z80_latch_clr_cs, z80_latch_r_cs, z80_rd_n, z80_wr_n,
        output z80_m1_n, z80_iorq_n,
        input  latch_dout, latch_oe, z80_irq_n, latch_full
    );

endinterface

// File: rtl/z80_irq_timer.sv
// Free-running Z80 IRQ pacer: divides z80_clk_en by IRQ_DIV and holds INT low
// until an M1+IORQ acknowledge; a tick always beats a simultaneous acknowledge.
module z80_irq_timer #(
    parameter int IRQ_DIV = 512,
    parameter int CNT_W   = 10
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic z80_clk_en,
    input  logic z80_m1_n,
    input  logic z80_iorq_n,
    output logic z80_irq_n
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IRQ_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_n_q, irq_n_d;
    logic             tick;
    logic             ack;

    assign tick = z80_clk_en & (cnt_q == CNT_LAST);
    assign ack  = z80_clk_en & ~z80_m1_n & ~z80_iorq_n;

    always_comb begin
        cnt_d   = cnt_q;
        irq_n_d = irq_n_q;
        if (z80_clk_en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
        if (tick) begin
            irq_n_d = 1'b0;
        end else if (ack) begin
            irq_n_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            irq_n_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            irq_n_q <= irq_n_d;
        end
    end

    assign z80_irq_n = irq_n_q;

endmodule

// File: rtl/sound_latch_irq.sv
// 68000-to-Z80 sound command latch with one capture per 68000 write cycle,
// Z80-side clear/read, and the periodic Z80 IRQ that paces the sound driver.
module sound_latch_irq #(
    parameter int IRQ_DIV = terracresta_pkg::IRQ_DIV_DFLT,
    parameter int CNT_W   = terracresta_pkg::IRQ_CNT_W_DFLT
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    sound_latch_irq_if.slave bus
);

    import terracresta_pkg::*;

    logic         wr_act;
    logic         wr_act_q, wr_act_d;
    logic         wr_edge;
    logic         z80_clr;
    sound_latch_t latch_q, latch_d;

    assign wr_act  = bus.sound_latch_cs & ~bus.m68k_rw & ~bus.m68k_lds_n;
    assign wr_edge = wr_act & ~wr_act_q;
    assign z80_clr = bus.z80_clk_en & bus.z80_latch_clr_cs & ~bus.z80_wr_n;

    // A fresh 68000 command must never be lost to a coincident Z80 clear.
    always_comb begin
        wr_act_d = wr_act;
        latch_d  = latch_q;
        if (wr_edge) begin
            latch_d.data = sound_cmd_xform(bus.m68k_dout);
            latch_d.full = 1'b1;
        end else if (z80_clr) begin
            latch_d = SOUND_LATCH_RST;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_act_q <= 1'b0;
            latch_q  <= SOUND_LATCH_RST;
        end else begin
            wr_act_q <= wr_act_d;
            latch_q  <= latch_d;
        end
    end

    assign bus.latch_dout = latch_q.data;
    assign bus.latch_full = latch_q.full;
    assign bus.latch_oe   = bus.z80_latch_r_cs & ~bus.z80_rd_n;

    z80_irq_timer #(
        .IRQ_DIV (IRQ_DIV),
        .CNT_W   (CNT_W)
    ) u_irq_timer (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .z80_clk_en (bus.z80_clk_en),
        .z80_m1_n   (bus.z80_m1_n),
        .z80_iorq_n (bus.z80_iorq_n),
        .z80_irq_n  (bus.z80_irq_n)
    );

endmodule
